// File: rtl/adder_sum_stage_if.sv
// Handshake bundle for the adder sum stage.
// Upstream prefix vectors in, registered sum/flags out.
`ifndef LEN_DATA
`define LEN_DATA 64
`endif

interface adder_sum_stage_if #(
  parameter int WIDTH = `LEN_DATA
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] g_prefix;
  logic [WIDTH-1:0] p_prefix;
  logic [WIDTH-1:0] p_bit;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid,
    output g_prefix,
    output p_prefix,
    output p_bit,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  ovf,
    input  zero,
    input  neg
  );

  modport slave (
    input  in_valid,
    input  g_prefix,
    input  p_prefix,
    input  p_bit,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output ovf,
    output zero,
    output neg
  );
endinterface

// File: rtl/adder_sum_stage.sv
// Final prefix-adder stage: sum, carry and flags,
// registered behind a one-entry skid buffer.
`ifndef LEN_DATA
`define LEN_DATA 64
`endif

module adder_sum_stage #(
  parameter int WIDTH = `LEN_DATA
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_sum_stage_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
  } res_t;

  // {out_valid, skid_valid}; 01 never occurs
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  res_t   main_q, main_d;
  res_t   skid_q, skid_d;

  logic [WIDTH:0] carry;
  res_t           res;
  logic           skid_valid;
  logic           acc;
  logic           drn;

  assign skid_valid = state_q[0];

  // Carries come straight from the resolved prefix vectors
  always_comb begin
    carry          = '0;
    carry[0]       = bus.cin;
    carry[WIDTH:1] = bus.g_prefix
                   | (bus.p_prefix & {WIDTH{bus.cin}});
    res            = '0;
    res.sum        = bus.p_bit ^ carry[WIDTH-1:0];
    res.cout       = carry[WIDTH];
    res.ovf        = carry[WIDTH] ^ carry[WIDTH-1];
    res.zero       = (res.sum == '0);
    res.neg        = res.sum[WIDTH-1];
  end

  assign acc = bus.in_valid & ~skid_valid;
  assign drn = state_q[1] & bus.out_ready;

  // Slot occupancy and data movement
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = res;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && drn) begin
          main_d = res;
        end else if (acc) begin
          skid_d  = res;
          state_d = FULL;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drn) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Result slots and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = state_q[1];
  assign bus.sum       = main_q.sum;
  assign bus.cout      = main_q.cout;
  assign bus.ovf       = main_q.ovf;
  assign bus.zero      = main_q.zero;
  assign bus.neg       = main_q.neg;

endmodule

// File: tb/tb_adder_sum_stage.sv
// Scoreboard bench for adder_sum_stage.
// Directed vectors, back-pressure, reset, random sweep.
module tb_adder_sum_stage;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   ready_mode;
  exp_t q[$];

  adder_sum_stage_if #(.WIDTH(W)) bus ();

  adder_sum_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [W-1:0] s,
    input logic c, input logic o,
    input logic z, input logic n
  );
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o;
    e.zero = z; e.neg = n;
    return e;
  endfunction

  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic ci
  );
    exp_t e;
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    e.zero = (t[W-1:0] == '0);
    e.neg  = t[W-1];
    return e;
  endfunction

  task automatic prefix(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] gp,
    output logic [W-1:0] pp
  );
    logic g, p;
    g = 1'b0;
    p = 1'b1;
    for (int i = 0; i < W; i++) begin
      g = (a[i] & b[i]) | ((a[i] ^ b[i]) & g);
      p = p & (a[i] ^ b[i]);
      gp[i] = g;
      pp[i] = p;
    end
  endtask

  task automatic chk(input string nm, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0b want=%0b", nm, got, req);
    end
  endtask

  // Present one operation and wait for its accept
  task automatic send(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic ci,
    input exp_t e
  );
    logic [W-1:0] gp, pp;
    bit done;
    prefix(a, b, gp, pp);
    bus.in_valid = 1'b1;
    bus.g_prefix = gp;
    bus.p_prefix = pp;
    bus.p_bit    = a ^ b;
    bus.cin      = ci;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout a=%h b=%h", a, b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit done;
    done = 0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", q.size());
    end
  endtask

  // Downstream ready: 0 stall, 1 always, 2 random
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b0;
        1: bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: compare every presented result with the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output sum=%h want=none", bus.sum);
        end else begin
          if (bus.sum !== q[0].sum || bus.cout !== q[0].cout ||
              bus.ovf !== q[0].ovf || bus.zero !== q[0].zero ||
              bus.neg !== q[0].neg) begin
            errors++;
            $display("FAIL result got=%h c%0b v%0b z%0b n%0b want=%h c%0b v%0b z%0b n%0b",
                     bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg,
                     q[0].sum, q[0].cout, q[0].ovf, q[0].zero, q[0].neg);
          end
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    logic ci;
    checks = 0;
    errors = 0;
    ready_mode = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.g_prefix = '0;
    bus.p_prefix = '0;
    bus.p_bit    = '0;
    bus.cin      = 1'b0;

    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_sum_zero", bus.sum == '0, 1'b1);
    chk("rst_zero_flag", bus.zero, 1'b0);
    #11 rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;

    send(64'h3, 64'h5, 1'b0, mk(64'h8, 0, 0, 0, 0));
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
         mk(64'h8000_0000_0000_0000, 0, 1, 0, 1));
    send(64'h1234, ~64'h1234, 1'b1, mk(64'h0, 1, 0, 1, 0));
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
         mk(64'h0, 1, 0, 1, 0));
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
         mk(64'h0, 1, 1, 1, 0));
    wait_empty();

    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(64'h0, 64'h1, 1'b0, mk(64'h1, 0, 0, 0, 0));
    send(64'h1, 64'h1, 1'b0, mk(64'h2, 0, 0, 0, 0));
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    fork
      send(64'h1, 64'h1, 1'b1, mk(64'h3, 0, 0, 0, 0));
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("bp_out_valid_held", bus.out_valid, 1'b1);
        chk("bp_sum_held", bus.sum == 64'h1, 1'b1);
        ready_mode = 1;
      end
    join
    wait_empty();

    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(64'h10, 64'h1, 1'b0, mk(64'h11, 0, 0, 0, 0));
    send(64'h20, 64'h2, 1'b0, mk(64'h22, 0, 0, 0, 0));
    chk("full_in_ready", bus.in_ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_sum", bus.sum == '0, 1'b1);
    chk("mid_rst_zero", bus.zero, 1'b0);
    chk("mid_rst_flags", bus.cout | bus.ovf | bus.neg, 1'b0);
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    send(64'd10, 64'd20, 1'b0, mk(64'd30, 0, 0, 0, 0));
    wait_empty();

    ready_mode = 2;
    for (int n = 0; n < 2000; n++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      ci = 1'($urandom_range(1));
      case ($urandom_range(7))
        0: b = ~a;
        1: a = '1;
        2: b = '0;
        default: ;
      endcase
      while ($urandom_range(3) == 0) begin
        bus.p_bit = {$urandom, $urandom};
        bus.cin   = 1'($urandom_range(1));
        @(posedge clk);
        #1;
      end
      send(a, b, ci, model(a, b, ci));
    end
    ready_mode = 1;
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
